// File: rtl/tensor_add_arbiter_pkg.sv
// Shared types and helpers for the tensor-scalar adder arbiter.
// Optional float support is selected with the TENSOR_ADD_ARB_FLOAT_EN macro.
package tensor_add_arbiter_pkg;

    // Default number of enabled cycles from float issue to adder result
    localparam int FLOAT_LATENCY_DEFAULT = 3;

    // Tag ID width sized for the largest supported requester count (8)
    localparam int TAG_ID_W = 3;

    // One entry of the float tag pipe: which requester owns the op in flight
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Round-robin pointer advance: the requester after cur, wrapping at num
    function automatic logic [TAG_ID_W-1:0] rr_next(input logic [TAG_ID_W-1:0] cur,
                                                    input int                  num);
        logic [TAG_ID_W:0] inc;
        logic [TAG_ID_W:0] lim;
        inc = {1'b0, cur} + 1'b1;
        lim = num[TAG_ID_W:0];
        if (inc >= lim) begin
            return '0;
        end
        return inc[TAG_ID_W-1:0];
    endfunction

endpackage

// File: rtl/tensor_add_arbiter_tag_pipe.sv
// Requester-ID shift register that runs in lockstep with the adder's float
// pipeline, so the tail entry names the owner of the result leaving the adder.
// Only instantiated when TENSOR_ADD_ARB_FLOAT_EN is defined.
module tensor_add_tag_pipe
    import tensor_add_arbiter_pkg::*;
#(
    parameter int DEPTH = FLOAT_LATENCY_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  tag_t push_i,
    output tag_t tail_o,
    output logic busy_o
);

    tag_t [DEPTH-1:0] pipe_q;
    tag_t [DEPTH-1:0] pipe_d;

    // Shift one slot per enabled cycle, mirroring the adder pipeline advance
    always_comb begin
        pipe_d = pipe_q;
        if (en_i) begin
            pipe_d[0] = push_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    // Tag state register; reset empties every slot
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Busy whenever any float op is still travelling through the adder
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_o = busy_o | pipe_q[i].valid;
        end
    end

    assign tail_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/tensor_add_arbiter.sv
// Round-robin arbiter and sequencer sharing one tensor-scalar adder among
// NUM_REQ requesters, with a single registered, ID-tagged response channel.
// Define TENSOR_ADD_ARB_FLOAT_EN for float mode (tag pipe + integer drain-hold);
// without it every op is integer with one-cycle latency.
module tensor_add_arbiter
    import tensor_add_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int BW_ID         = $clog2(NUM_REQ),
    parameter int BW_DATA       = 32,
    parameter int FLOAT_LATENCY = FLOAT_LATENCY_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*BW_DATA-1:0] req_operand0,
    input  logic [NUM_REQ*BW_DATA-1:0] req_operand1,
    input  logic [NUM_REQ-1:0]         req_is_sub,
    input  logic [NUM_REQ-1:0]         req_is_float,
    output logic                       adder_enable,
    output logic                       adder_in_valid,
    output logic                       adder_is_sub,
    output logic                       adder_is_float,
    output logic [BW_DATA-1:0]         adder_operand0,
    output logic [BW_DATA-1:0]         adder_operand1,
    input  logic                       adder_out_valid,
    input  logic [BW_DATA-1:0]         adder_out_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [BW_ID-1:0]           rsp_id,
    output logic [BW_DATA-1:0]         rsp_data
);

    logic                stall;
    logic                issue;
    logic                hold;
    logic                int_issue;
    logic                win_found;
    logic                win_float;
    logic                pipe_busy;
    logic                tail_valid;
    logic                rsp_load;
    logic [TAG_ID_W-1:0] rr_ptr_q;
    logic [TAG_ID_W-1:0] rr_ptr_d;
    logic [TAG_ID_W-1:0] win_id;
    logic [TAG_ID_W-1:0] tail_id;
    logic [NUM_REQ-1:0]  rot_valid;
    int                  win_off;
    int                  win_sum;
    logic [BW_DATA-1:0]  sel_op0;
    logic [BW_DATA-1:0]  sel_op1;
    logic                sel_sub;
    logic                sel_float;
    logic                rsp_valid_q;
    logic                rsp_valid_d;
    logic [BW_ID-1:0]    rsp_id_q;
    logic [BW_ID-1:0]    rsp_id_d;
    logic [BW_DATA-1:0]  rsp_data_q;
    logic [BW_DATA-1:0]  rsp_data_d;

    // A held response freezes both issue and the adder pipeline
    assign stall        = rsp_valid_q & ~rsp_ready;
    assign adder_enable = ~stall;

    // Rotate the request vector so bit 0 is the requester at rr_ptr
    assign rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);

    // Pick the first valid requester at or after rr_ptr
    always_comb begin
        win_found = 1'b0;
        win_off   = 0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot_valid[j]) begin
                win_found = 1'b1;
                win_off   = j;
            end
        end
        win_sum = int'(rr_ptr_q) + win_off;
        if (win_sum >= NUM_REQ) begin
            win_sum = win_sum - NUM_REQ;
        end
        win_id = TAG_ID_W'(win_sum);
    end

    // Mux the winner's operands and flags onto the adder inputs
    always_comb begin
        sel_op0   = '0;
        sel_op1   = '0;
        sel_sub   = 1'b0;
        sel_float = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == TAG_ID_W'(i)) begin
                sel_op0   = req_operand0[i*BW_DATA +: BW_DATA];
                sel_op1   = req_operand1[i*BW_DATA +: BW_DATA];
                sel_sub   = req_is_sub[i];
                sel_float = req_is_float[i];
            end
        end
    end

`ifdef TENSOR_ADD_ARB_FLOAT_EN
    tag_t tag_push;
    tag_t tag_tail;

    assign win_float = sel_float;
    // An integer result is combinational, so it must wait for floats to drain
    assign hold      = win_found & ~win_float & pipe_busy;
    assign tag_push  = {issue & win_float, win_id};

    tensor_add_tag_pipe #(
        .DEPTH (FLOAT_LATENCY)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .en_i   (adder_enable),
        .push_i (tag_push),
        .tail_o (tag_tail),
        .busy_o (pipe_busy)
    );

    assign tail_valid = tag_tail.valid;
    assign tail_id    = tag_tail.id;
`else
    logic unused_float;
    localparam int unused_latency = FLOAT_LATENCY;

    assign unused_float = sel_float;
    assign win_float    = 1'b0;
    assign hold         = 1'b0;
    assign pipe_busy    = 1'b0;
    assign tail_valid   = 1'b0;
    assign tail_id      = '0;
`endif

    assign issue     = ~rst & win_found & ~stall & ~hold;
    assign int_issue = issue & ~win_float;

    assign req_ready      = issue ? (NUM_REQ'(1) << win_id) : '0;
    assign adder_in_valid = issue;
    assign adder_operand0 = sel_op0;
    assign adder_operand1 = sel_op1;
    assign adder_is_sub   = sel_sub;
    // Float mode stays asserted while results are in flight so the adder keeps draining
    assign adder_is_float = ~rst & ((issue & win_float) | pipe_busy);

    // Advance the round-robin pointer past each granted requester
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = rr_next(win_id, NUM_REQ);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Results are only accepted when someone owns them: a float tag or a live integer issue
    assign rsp_load = adder_enable & adder_out_valid & (tail_valid | int_issue);

    // Response register next state: reload on a new result, else clear on accept
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (rsp_load) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = tail_valid ? BW_ID'(tail_id) : BW_ID'(win_id);
            rsp_data_d  = adder_out_data;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response register; reset drops any pending response
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

    // An adder result nobody issued is a protocol error from the adder side
    a_owned_result: assert property (@(posedge clk) disable iff (rst)
        !(adder_enable && adder_out_valid && !tail_valid && !int_issue));

endmodule

// File: tb/tb_tensor_add_arbiter.sv
// Directed bench for tensor_add_arbiter with a behavioural shared adder:
// integer ops are combinational, float ops (positive normals) take three
// enabled cycles. Expectations follow TENSOR_ADD_ARB_FLOAT_EN when defined.
module tb_tensor_add_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_operand0;
    logic [127:0] req_operand1;
    logic [3:0]   req_is_sub;
    logic [3:0]   req_is_float;
    logic         adder_enable;
    logic         adder_in_valid;
    logic         adder_is_sub;
    logic         adder_is_float;
    logic [31:0]  adder_operand0;
    logic [31:0]  adder_operand1;
    logic         adder_out_valid;
    logic [31:0]  adder_out_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;

    int total = 0;
    int bad   = 0;

    tensor_add_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_operand0    (req_operand0),
        .req_operand1    (req_operand1),
        .req_is_sub      (req_is_sub),
        .req_is_float    (req_is_float),
        .adder_enable    (adder_enable),
        .adder_in_valid  (adder_in_valid),
        .adder_is_sub    (adder_is_sub),
        .adder_is_float  (adder_is_float),
        .adder_operand0  (adder_operand0),
        .adder_operand1  (adder_operand1),
        .adder_out_valid (adder_out_valid),
        .adder_out_data  (adder_out_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared adder model ----------------
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb, e;
        logic [24:0] ma, mb, s, t;
        ea = a[30:23];
        eb = b[30:23];
        ma = {2'b01, a[22:0]};
        mb = {2'b01, b[22:0]};
        if (ea < eb) begin
            t = ma; ma = mb; mb = t;
            e = ea; ea = eb; eb = e;
        end
        mb = mb >> (ea - eb);
        e  = ea;
        s  = ma + mb;
        if (s[24]) begin
            s = s >> 1;
            e = e + 8'd1;
        end
        return {1'b0, e, s[22:0]};
    endfunction

    logic [2:0]  fv;
    logic [31:0] fd0, fd1, fd2;

    always @(posedge clk) begin
        if (rst) begin
            fv <= 3'b000;
        end else if (adder_enable) begin
            fv  <= {fv[1:0], adder_in_valid & adder_is_float};
            fd0 <= fadd(adder_operand0, adder_operand1);
            fd1 <= fd0;
            fd2 <= fd1;
        end
    end

    assign adder_out_valid = fv[2] | (adder_in_valid & ~adder_is_float);
    assign adder_out_data  = fv[2] ? fd2 :
                             (adder_is_sub ? adder_operand0 - adder_operand1
                                           : adder_operand0 + adder_operand1);

    // ---------------- response monitor ----------------
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } rsp_t;
    rsp_t got_q[$];

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            got_q.push_back({rsp_id, rsp_data});
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic flt);
        req_operand0[i*32 +: 32] = a;
        req_operand1[i*32 +: 32] = b;
        req_is_sub[i]            = sub;
        req_is_float[i]          = flt;
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp;
    } vec_t;

`ifdef TENSOR_ADD_ARB_FLOAT_EN
    localparam logic        FLOAT_ON = 1'b1;
    localparam logic [31:0] BP_EXP0  = 32'h4000_0000;
    localparam logic [31:0] BP_EXP1  = 32'h4040_0000;
    localparam logic [31:0] BP_EXP2  = 32'h4070_0000;
`else
    localparam logic        FLOAT_ON = 1'b0;
    localparam logic [31:0] BP_EXP0  = 32'h7F00_0000;
    localparam logic [31:0] BP_EXP1  = 32'h7F80_0000;
    localparam logic [31:0] BP_EXP2  = 32'h7FD0_0000;
`endif

    initial begin
        vec_t        vecs[5];
        int          rr_grant[5];
        int          rr_id[4];
        logic [31:0] rr_data[4];
        int          stale;

        vecs[0] = '{id: 2, a: 32'd5,          b: 32'd7, sub: 1'b0, exp: 32'd12};
        vecs[1] = '{id: 0, a: 32'd100,        b: 32'd1, sub: 1'b1, exp: 32'd99};
        vecs[2] = '{id: 3, a: 32'hFFFF_FFFF,  b: 32'd1, sub: 1'b0, exp: 32'h0000_0000};
        vecs[3] = '{id: 1, a: 32'd0,          b: 32'd1, sub: 1'b1, exp: 32'hFFFF_FFFF};
        vecs[4] = '{id: 2, a: 32'h7FFF_FFFF,  b: 32'd1, sub: 1'b0, exp: 32'h8000_0000};
        rr_grant = '{1, 2, 4, 8, 1};
        rr_id    = '{0, 1, 2, 3};
        rr_data  = '{32'd3, 32'd30, 32'd300, 32'd3000};

        // ---- reset values, with requests pending ----
        rst          = 1'b1;
        req_valid    = 4'hF;
        req_operand0 = '0;
        req_operand1 = '0;
        req_is_sub   = '0;
        req_is_float = '0;
        rsp_ready    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_in_valid", 32'(adder_in_valid), 32'h0);
        chk("reset_is_float", 32'(adder_is_float), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_id", 32'(rsp_id), 32'h0);
        chk("reset_rsp_data", rsp_data, 32'h0);
        tick();
        rst       = 1'b0;
        req_valid = 4'h0;
        tick();

        // ---- round-robin with all requesters integer-valid ----
        set_req(0, 32'd1,    32'd2,    1'b0, 1'b0);
        set_req(1, 32'd10,   32'd20,   1'b0, 1'b0);
        set_req(2, 32'd100,  32'd200,  1'b0, 1'b0);
        set_req(3, 32'd1000, 32'd2000, 1'b0, 1'b0);
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 5) begin
                chk($sformatf("rr_grant_%0d", k), 32'(req_ready), rr_grant[k]);
                chk($sformatf("rr_enable_%0d", k), 32'(adder_enable), 32'h1);
            end
            if (k >= 1) begin
                chk($sformatf("rr_rsp_valid_%0d", k), 32'(rsp_valid), 32'h1);
                chk($sformatf("rr_rsp_id_%0d", k), 32'(rsp_id), rr_id[(k-1)%4]);
                chk($sformatf("rr_rsp_data_%0d", k), rsp_data, rr_data[(k-1)%4]);
            end
            tick();
            if (k == 4) req_valid = 4'h0;
        end

        // ---- table-driven single integer ops ----
        for (int v = 0; v < 5; v++) begin
            set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sub, 1'b0);
            req_valid = 4'(1 << vecs[v].id);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", v), 32'(req_ready), 1 << vecs[v].id);
            chk($sformatf("vec%0d_in_valid", v), 32'(adder_in_valid), 32'h1);
            chk($sformatf("vec%0d_operand0", v), adder_operand0, vecs[v].a);
            chk($sformatf("vec%0d_is_sub", v), 32'(adder_is_sub), 32'(vecs[v].sub));
            tick();
            req_valid = 4'h0;
            @(negedge clk);
            chk($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'h1);
            chk($sformatf("vec%0d_rsp_id", v), 32'(rsp_id), vecs[v].id);
            chk($sformatf("vec%0d_rsp_data", v), rsp_data, vecs[v].exp);
            tick();
        end

        // ---- float from requester 0, then integer from requester 1 ----
        set_req(0, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b1);
        set_req(1, 32'd20, 32'd22, 1'b0, 1'b0);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("fi_float_grant", 32'(req_ready), 32'h1);
        chk("fi_float_mode", 32'(adder_is_float), 32'(FLOAT_ON));
        tick();
        req_valid = 4'b0010;
`ifdef TENSOR_ADD_ARB_FLOAT_EN
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("fi_hold_ready_t%0d", c), 32'(req_ready), 32'h0);
            chk($sformatf("fi_hold_mode_t%0d", c), 32'(adder_is_float), 32'h1);
            chk($sformatf("fi_hold_rsp_t%0d", c), 32'(rsp_valid), 32'h0);
            tick();
        end
`endif
        @(negedge clk);
        chk("fi_float_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("fi_float_rsp_id", 32'(rsp_id), 32'h0);
        chk("fi_float_rsp_data", rsp_data, FLOAT_ON ? 32'h4070_0000 : 32'h7FD0_0000);
        chk("fi_int_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'h0;
        @(negedge clk);
        chk("fi_int_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("fi_int_rsp_id", 32'(rsp_id), 32'h1);
        chk("fi_int_rsp_data", rsp_data, 32'd42);
        tick();

        // ---- backpressure with three ops in flight ----
        got_q.delete();
        set_req(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b1);
        set_req(1, 32'h4000_0000, 32'h3F80_0000, 1'b0, 1'b1);
        set_req(2, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b1);
        set_req(3, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b1);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        tick();
        req_valid = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("bp_enable_%0d", c), 32'(adder_enable), 32'h0);
            chk($sformatf("bp_ready_%0d", c), 32'(req_ready), 32'h0);
            chk($sformatf("bp_rsp_held_%0d", c), 32'(rsp_valid), 32'h1);
            tick();
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        for (int w = 0; w < 20 && got_q.size() < 3; w++) @(posedge clk);
        chk("bp_rsp_count", got_q.size(), 32'd3);
        if (got_q.size() >= 3) begin
            chk("bp_rsp0_id", 32'(got_q[0].id), 32'd0);
            chk("bp_rsp0_data", got_q[0].data, BP_EXP0);
            chk("bp_rsp1_id", 32'(got_q[1].id), 32'd1);
            chk("bp_rsp1_data", got_q[1].data, BP_EXP1);
            chk("bp_rsp2_id", 32'(got_q[2].id), 32'd2);
            chk("bp_rsp2_data", got_q[2].data, BP_EXP2);
        end
        #1;
        repeat (3) tick();

        // ---- reset with two ops in flight ----
        set_req(2, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b1);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        rst       = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_in_valid", 32'(adder_in_valid), 32'h0);
        chk("mid_rst_is_float", 32'(adder_is_float), 32'h0);
        tick();
        rst       = 1'b0;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("post_rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("post_rst_rsp_data", rsp_data, 32'h0);
        chk("post_rst_is_float", 32'(adder_is_float), 32'h0);
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        chk("post_rst_stale_rsp", stale, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tensor_add_arbiter.md
# tensor_add_arbiter

Round-robin arbiter and sequencer that shares one tensor-scalar adder among NUM_REQ requesters. Each request carries two operands, a subtract flag and a float/integer mode flag. The block drives the adder's valid, enable and mode inputs and tracks requester IDs through the float pipeline. It returns every result on a single registered response channel tagged with the originating requester. It sits between the tensor engine's lane controllers and the shared adder instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- BW_ID, $clog2(NUM_REQ), requester ID width
- BW_DATA, 32, scalar operand/result width
- FLOAT_LATENCY, 3, enabled cycles from float issue to adder result
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_operand0 / req_operand1  in  NUM_REQ*BW_DATA  packed operands, requester i at slice i
- req_is_sub  in  NUM_REQ  subtract operand1
- req_is_float  in  NUM_REQ  float32 mode; integer otherwise
- adder_enable  out  1  adder pipeline advance
- adder_in_valid / adder_is_sub / adder_is_float  out  1  adder controls
- adder_operand0 / adder_operand1  out  BW_DATA  adder inputs
- adder_out_valid  in  1  adder result valid
- adder_out_data  in  BW_DATA  adder result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  BW_ID  requester ID of response
- rsp_data  out  BW_DATA  result

## Operation
- stall = rsp_valid & ~rsp_ready.
- adder_enable = ~stall.
- No issue while stall is asserted.
- Arbitration is round-robin from pointer rr_ptr over requesters with req_valid, giving the winner W.
- Pipe-busy = any valid entry in the tag pipe.
- If W is integer and pipe-busy: hold. Nothing issues, all req_ready are 0 and rr_ptr is unchanged. This drains in-flight float results so they cannot collide with the combinational integer result.
- Otherwise, when not stalled, W issues:
  - req_ready[W] = 1
  - adder_in_valid = 1
  - operands, is_sub and is_float are muxed from W
  - rr_ptr <= W+1 (mod NUM_REQ)
- adder_is_float = (issuing float) | pipe-busy.
  - When idle it holds 1 while pipe-busy, else 0.
- Tag pipe: FLOAT_LATENCY entries of {valid, id}.
  - Shifts only when adder_enable.
  - Entry 0 loads {1, W} on float issue, else {0, x}.
- Response register:
  - Loads when adder_enable & adder_out_valid.
  - rsp_id = tail tag ID for a float result; the issuing W for an integer result.
  - Otherwise rsp_valid clears when rsp_ready.
- Throughput: one op per cycle with rsp_ready held high and no mode hazard.
- Reset values:
  - req_ready = 0, adder_in_valid = 0, adder_is_float = 0
  - rr_ptr = 0, tag pipe all invalid
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0
- Reset mid-operation drops all in-flight ops with no response. The parent resets the adder from the same rst.
- Simultaneous rsp_ready and a new adder result: the register reloads in the same cycle, with no bubble.
- Adder result while the tail tag is invalid and no integer issue is in progress is a protocol error. It is ignored and flagged in simulation by an assertion.

## Timing
- Integer: accepted at cycle t, rsp_valid at t+1.
- Float: accepted at t, rsp_valid at t+1+FLOAT_LATENCY (t+4 by default), plus one cycle per stalled cycle.
- Integer following float: first integer issue is at least FLOAT_LATENCY cycles after the last float issue.
- req_ready depends combinationally on req_valid and rsp_ready; there is no combinational path from req_* to rsp_*.

## Configuration
- TENSOR_ADD_ARB_FLOAT_EN defined:
  - full float support as above
  - tag pipe present
  - integer drain-hold active
- TENSOR_ADD_ARB_FLOAT_EN undefined:
  - req_is_float is ignored and adder_is_float is tied 0
  - no tag pipe and no hold rule; every op is integer with 1-cycle latency

## Structure
- Shared package holds:
  - default FLOAT_LATENCY
  - tag entry type {valid, id}
  - the round-robin next-pointer function
- Sub-module tensor_add_tag_pipe holds the FLOAT_LATENCY-deep shift register, with enable, push and tail outputs.
- Arbiter, hold logic and response register stay in the top module.

## Test plan
- Single integer: requester 2 sends 5 + 7 with rsp_ready = 1 → rsp_valid next cycle with rsp_id = 2, rsp_data = 12.
- Round-robin: all 4 requesters integer-valid continuously → grants 0,1,2,3,0 on consecutive cycles with rsp_id following the same sequence.
- Float then integer: requester 0 float 1.5 + 2.25 (0x3FC00000 + 0x40100000) at t, requester 1 integer at t+1 → requester 1 held until t+3:
  - rsp 0x40700000 with id 0 at t+4
  - integer response at t+4 or later, never colliding
- Backpressure: 3 floats issued, rsp_ready = 0 for 5 cycles → adder_enable = 0 and req_ready = 0 throughout; all 3 results arrive in issue order with no loss once ready rises.
- Reset mid-flight: rst pulsed with 2 floats in flight → all outputs return to reset values and no stale response ever appears.
